pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 141 ++++++++++++++
 tb/tb_pipe_skid_reg.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry skid register slice with registered in_ready.
// Optional performance counters: define PIPE_SKID_REG_PERF_CNT_EN.
module pipe_skid_reg #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              in_ready_q;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic              accept;
   logic              drain;

   assign out_valid = (state_q != EMPTY);
   assign accept    = in_valid & in_ready_q;
   assign drain     = out_valid & out_ready;

   always_comb begin
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d     = ONE;
                  main_ctrl_d = in_ctrl;
                  main_data_d = in_data;
               end
            end
            ONE: begin
               if (accept && drain) begin
                  main_ctrl_d = in_ctrl;
                  main_data_d = in_data;
               end else if (accept) begin
                  state_d     = FULL;
                  skid_ctrl_d = in_ctrl;
                  skid_data_d = in_data;
               end else if (drain) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               // in_ready is low here, so only a drain can change anything
               if (drain) begin
                  state_d     = ONE;
                  main_ctrl_d = skid_ctrl_q;
                  main_data_d = skid_data_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= EMPTY;
         in_ready_q  <= 1'b1;
         main_ctrl_q <= '0;
         main_data_q <= '0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= (state_d != FULL);
         main_ctrl_q <= main_ctrl_d;
         main_data_q <= main_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_data_q <= skid_data_d;
      end
   end

   assign in_ready = in_ready_q;
   // Bubbles must never present a write enable downstream.
   assign out_ctrl = out_valid ? main_ctrl_q : '0;
   assign out_data = main_data_q;

`ifdef PIPE_SKID_REG_PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      if (!out_valid && (bubble_cnt_q != '1)) begin
         bubble_cnt_d = bubble_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`else
   assign stall_cnt  = '0;
   assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - randomized and directed bench for pipe_skid_reg against a queue model.
// Counter checks follow PIPE_SKID_REG_PERF_CNT_EN.
module tb_pipe_skid_reg;

   localparam int DATA_W = 32;
   localparam int CTRL_W = 8;
   localparam int CNT_W  = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk;
   logic              reset;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  bubble_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Model: FIFO of {ctrl, data}, capacity two, plus last shown payload.
   logic [CTRL_W+DATA_W-1:0] mq[$];
   logic [DATA_W-1:0]        m_last_data;
   int                       m_stall;
   int                       m_bubble;

   pipe_skid_reg #(
      .DATA_W(DATA_W),
      .CTRL_W(CTRL_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data),
      .stall_cnt (stall_cnt),
      .bubble_cnt(bubble_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_last_data = '0;
      m_stall     = 0;
      m_bubble    = 0;
   endtask

   function automatic int exp_cnt(input int v);
`ifdef PIPE_SKID_REG_PERF_CNT_EN
      return (v > CNT_MAX) ? CNT_MAX : v;
`else
      return 0 * v;
`endif
   endfunction

   task automatic check_outputs();
      logic [CTRL_W+DATA_W-1:0] head;
      head = (mq.size() > 0) ? mq[0] : '0;
      check_eq("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      check_eq("in_ready", 64'(in_ready), 64'(mq.size() < 2));
      check_eq("out_ctrl", 64'(out_ctrl), 64'(head[CTRL_W+DATA_W-1:DATA_W]));
      check_eq("out_data", 64'(out_data), (mq.size() > 0) ? 64'(head[DATA_W-1:0]) : 64'(m_last_data));
      check_eq("stall_cnt", 64'(stall_cnt), 64'(exp_cnt(m_stall)));
      check_eq("bubble_cnt", 64'(bubble_cnt), 64'(exp_cnt(m_bubble)));
   endtask

   task automatic model_update(input logic iv, input logic [CTRL_W-1:0] ic,
                               input logic [DATA_W-1:0] id, input logic ordy, input logic fl);
      logic acc, drn;
      acc = iv && (mq.size() < 2);
      drn = ordy && (mq.size() > 0);
      if (mq.size() > 0 && !ordy) m_stall++;
      if (mq.size() == 0) m_bubble++;
      if (m_stall > CNT_MAX) m_stall = CNT_MAX;
      if (m_bubble > CNT_MAX) m_bubble = CNT_MAX;
      if (fl) begin
         mq.delete();
      end else begin
         if (drn) void'(mq.pop_front());
         if (acc) mq.push_back({ic, id});
      end
      if (mq.size() > 0) m_last_data = mq[0][DATA_W-1:0];
   endtask

   // Called at posedge+1: apply inputs, check at negedge, advance model at the edge.
   task automatic step(input logic iv, input logic [CTRL_W-1:0] ic, input logic [DATA_W-1:0] id,
                       input logic ordy, input logic fl);
      in_valid  = iv;
      in_ctrl   = ic;
      in_data   = id;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      check_outputs();
      model_update(iv, ic, id, ordy, fl);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
      model_reset();
      #1;
      do_reset();

      // Single entry: one-cycle latency from empty.
      step(1'b1, 8'h81, 32'h0000_00AA, 1'b1, 1'b0);
      check_eq("lat_valid", 64'(out_valid), 64'd1);
      check_eq("lat_ctrl", 64'(out_ctrl), 64'h81);
      check_eq("lat_data", 64'(out_data), 64'hAA);
      step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);

      // Back-pressure: third push held upstream, then drained in order.
      step(1'b1, 8'h01, 32'h1, 1'b0, 1'b0);
      step(1'b1, 8'h02, 32'h2, 1'b0, 1'b0);
      check_eq("bp_in_ready_low", 64'(in_ready), 64'd0);
      step(1'b1, 8'h03, 32'h3, 1'b0, 1'b0);
      check_eq("bp_hold_data", 64'(out_data), 64'h1);
      step(1'b1, 8'h03, 32'h3, 1'b1, 1'b0);
      check_eq("bp_out2", 64'(out_data), 64'h2);
      step(1'b1, 8'h03, 32'h3, 1'b1, 1'b0);
      check_eq("bp_out3", 64'(out_data), 64'h3);
      step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
      check_eq("bp_empty", 64'(out_valid), 64'd0);

      // Flush while FULL with an entry offered on the same cycle.
      step(1'b1, 8'hFF, 32'h10, 1'b0, 1'b0);
      step(1'b1, 8'hFF, 32'h11, 1'b0, 1'b0);
      step(1'b1, 8'hFF, 32'h12, 1'b0, 1'b1);
      check_eq("fl_valid", 64'(out_valid), 64'd0);
      check_eq("fl_ctrl", 64'(out_ctrl), 64'd0);
      check_eq("fl_in_ready", 64'(in_ready), 64'd1);
      repeat (3) begin
         step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
         check_eq("fl_no_12", 64'(out_valid), 64'd0);
      end

      // Long stall saturates the stall counter when enabled.
      step(1'b1, 8'h05, 32'h55, 1'b0, 1'b0);
      repeat (20) step(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
`ifdef PIPE_SKID_REG_PERF_CNT_EN
      check_eq("stall_sat", 64'(stall_cnt), 64'hF);
`else
      check_eq("stall_zero", 64'(stall_cnt), 64'h0);
`endif
      step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);

      // Randomized traffic with occasional flush.
      for (int i = 0; i < 10000; i++) begin
         step(1'($urandom_range(0, 1)), 8'($urandom), 32'($urandom),
              1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
      end

      // Asynchronous reset between edges while FULL.
      step(1'b1, 8'h21, 32'h21, 1'b0, 1'b0);
      step(1'b1, 8'h22, 32'h22, 1'b0, 1'b0);
      step(1'b1, 8'h22, 32'h22, 1'b0, 1'b0);
      check_eq("ar_full", 64'(in_ready), 64'd0);
      #2;
      reset = 1'b1;
      #1;
      check_eq("ar_valid", 64'(out_valid), 64'd0);
      check_eq("ar_in_ready", 64'(in_ready), 64'd1);
      check_eq("ar_ctrl", 64'(out_ctrl), 64'd0);
      check_eq("ar_data", 64'(out_data), 64'd0);
      check_eq("ar_stall", 64'(stall_cnt), 64'd0);
      in_valid = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(1'b1, 8'h33, 32'h33, 1'b1, 1'b0);
      check_eq("ar_after_data", 64'(out_data), 64'h33);
      repeat (4) step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
